// File: rtl/dm_unit.sv
// dm_unit: byte-addressable little-endian data memory with alignment checking, sticky error and store counter
module dm_unit #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  input  logic        MemWr,
  input  logic        MemRd,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  output logic [31:0] DataOut,
  output logic        AddrErr,
  output logic        ErrSticky,
  output logic [15:0] StoreCnt
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] word, word_d, wdata, bmask;
  logic [AW-1:0] idx;
  logic [7:0] b;
  logic [15:0] h;
  logic [3:0] be;
  logic we, err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    idx = Addr[AW+1:2];
    word = mem_q[idx];
    AddrErr = (MemRd | MemWr) & ((MemSize == 2'b01 & Addr[0]) | (MemSize == 2'b10 & |Addr[1:0]) | MemSize == 2'b11);
    b = word[8*Addr[1:0] +: 8];
    h = Addr[1] ? word[31:16] : word[15:0];
    DataOut = (!MemRd || AddrErr || rst) ? 32'h0 :
              MemSize == 2'b00 ? {{24{MemSigned & b[7]}}, b} :
              MemSize == 2'b01 ? {{16{MemSigned & h[15]}}, h} : word;
    be = MemSize == 2'b00 ? 4'b0001 << Addr[1:0] :
         MemSize == 2'b01 ? (Addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = MemSize == 2'b00 ? {4{DataIn[7:0]}} : MemSize == 2'b01 ? {2{DataIn[15:0]}} : DataIn;
    bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    word_d = (word & ~bmask) | (wdata & bmask);
    we = MemWr & ~AddrErr;
    err_d = err_q | AddrErr;
    cnt_d = cnt_q + 16'(we);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
      err_q <= 1'b0;
      cnt_q <= 16'h0;
    end else begin
      if (we) mem_q[idx] <= word_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign ErrSticky = err_q;
  assign StoreCnt = cnt_q;
endmodule

// File: tb/tb_dm_unit.sv
// tb_dm_unit: directed vector table plus reset and counter-wrap sequences for dm_unit
module tb_dm_unit;
  logic clk = 1'b0, rst = 1'b0, MemWr = 1'b0, MemRd = 1'b0, MemSigned = 1'b0;
  logic [31:0] Addr = '0, DataIn = '0, DataOut;
  logic [1:0] MemSize = '0;
  logic AddrErr, ErrSticky;
  logic [15:0] StoreCnt;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic wr, rd;
    logic [1:0] sz;
    logic sg;
    logic [31:0] a, d, out;
    logic err, stk;
    logic [15:0] cnt;
  } vec_t;
  vec_t v[$];
  dm_unit dut (.clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .MemWr(MemWr), .MemRd(MemRd),
    .MemSize(MemSize), .MemSigned(MemSigned), .DataOut(DataOut), .AddrErr(AddrErr),
    .ErrSticky(ErrSticky), .StoreCnt(StoreCnt));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic wr, input logic rd, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    rst = r; MemWr = wr; MemRd = rd; MemSize = sz; MemSigned = sg; Addr = a; DataIn = d;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(logic wr, logic rd, logic [1:0] sz, logic sg, logic [31:0] a, logic [31:0] d,
                              logic [31:0] out, logic err, logic stk, logic [15:0] cnt);
    vec_t t;
    t.wr = wr; t.rd = rd; t.sz = sz; t.sg = sg; t.a = a; t.d = d;
    t.out = out; t.err = err; t.stk = stk; t.cnt = cnt;
    return t;
  endfunction
  initial begin
    // expected DataOut/AddrErr are combinational for the vector; ErrSticky/StoreCnt are the state before its edge
    v.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'h12345678, 32'h0, 0, 0, 16'd0));
    v.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'h0, 32'h12345678, 0, 0, 16'd1));
    v.push_back(mk(1, 0, 2'b00, 0, 32'h11, 32'hFFFFFFAB, 32'h0, 0, 0, 16'd1));
    v.push_back(mk(0, 1, 2'b00, 1, 32'h11, 32'h0, 32'hFFFFFFAB, 0, 0, 16'd2));
    v.push_back(mk(0, 1, 2'b00, 0, 32'h11, 32'h0, 32'h000000AB, 0, 0, 16'd2));
    v.push_back(mk(0, 1, 2'b10, 1, 32'h10, 32'h0, 32'h1234AB78, 0, 0, 16'd2));
    v.push_back(mk(0, 1, 2'b01, 1, 32'h12, 32'h0, 32'h00001234, 0, 0, 16'd2));
    v.push_back(mk(0, 1, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFAB78, 0, 0, 16'd2));
    v.push_back(mk(0, 1, 2'b01, 0, 32'h10, 32'h0, 32'h0000AB78, 0, 0, 16'd2));
    v.push_back(mk(1, 0, 2'b01, 0, 32'h13, 32'hBEEF, 32'h0, 1, 0, 16'd2));
    v.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'h0, 32'h1234AB78, 0, 1, 16'd2));
    v.push_back(mk(0, 1, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1, 1, 16'd2));
    v.push_back(mk(0, 1, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1, 16'd2));
    v.push_back(mk(0, 0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 0, 1, 16'd2));
    v.push_back(mk(1, 0, 2'b10, 0, 32'h1020, 32'hCAFEF00D, 32'h0, 0, 1, 16'd2));
    v.push_back(mk(0, 1, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 1, 16'd3));
    v.push_back(mk(1, 0, 2'b10, 0, 32'h30, 32'h1, 32'h0, 0, 1, 16'd3));
    v.push_back(mk(1, 1, 2'b10, 0, 32'h30, 32'h2, 32'h1, 0, 1, 16'd4));
    v.push_back(mk(0, 1, 2'b10, 0, 32'h30, 32'h0, 32'h2, 0, 1, 16'd5));
    v.push_back(mk(1, 0, 2'b01, 0, 32'h22, 32'h99995566, 32'h0, 0, 1, 16'd5));
    v.push_back(mk(0, 1, 2'b10, 0, 32'h20, 32'h0, 32'h5566F00D, 0, 1, 16'd6));
    v.push_back(mk(0, 1, 2'b00, 0, 32'h20, 32'h0, 32'h0000000D, 0, 1, 16'd6));
    v.push_back(mk(0, 1, 2'b00, 1, 32'h23, 32'h0, 32'h00000055, 0, 1, 16'd6));
    step;
    drive(1, 0, 0, 2'b10, 0, 32'h0, 32'h0);
    step;
    step;
    drive(0, 0, 1, 2'b10, 0, 32'h10, 32'h0);
    #4;
    chk("reset DataOut", DataOut, 32'h0);
    chk("reset ErrSticky", 32'(ErrSticky), 32'h0);
    chk("reset StoreCnt", 32'(StoreCnt), 32'h0);
    step;
    for (int i = 0; i < v.size(); i++) begin
      drive(0, v[i].wr, v[i].rd, v[i].sz, v[i].sg, v[i].a, v[i].d);
      #4;
      chk($sformatf("v%0d DataOut", i), DataOut, v[i].out);
      chk($sformatf("v%0d AddrErr", i), 32'(AddrErr), 32'(v[i].err));
      chk($sformatf("v%0d ErrSticky", i), 32'(ErrSticky), 32'(v[i].stk));
      chk($sformatf("v%0d StoreCnt", i), 32'(StoreCnt), 32'(v[i].cnt));
      step;
    end
    drive(1, 1, 1, 2'b10, 0, 32'h0, 32'hFFFFFFFF);
    #4;
    chk("rst DataOut", DataOut, 32'h0);
    step;
    drive(0, 0, 1, 2'b10, 0, 32'h0, 32'h0);
    #4;
    chk("post-rst load 0x0", DataOut, 32'h0);
    chk("post-rst StoreCnt", 32'(StoreCnt), 32'h0);
    chk("post-rst ErrSticky", 32'(ErrSticky), 32'h0);
    step;
    drive(0, 0, 1, 2'b10, 0, 32'h20, 32'h0);
    #4;
    chk("post-rst load 0x20", DataOut, 32'h0);
    step;
    for (int i = 0; i < 65535; i++) begin
      drive(0, 1, 0, 2'b00, 0, 32'h41, 32'(i));
      step;
    end
    drive(0, 1, 0, 2'b00, 0, 32'h41, 32'h0);
    #4;
    chk("cnt at 0xFFFF", 32'(StoreCnt), 32'hFFFF);
    step;
    drive(0, 0, 1, 2'b10, 0, 32'h40, 32'h0);
    #4;
    chk("cnt wrapped", 32'(StoreCnt), 32'h0);
    chk("last byte store", DataOut, 32'h00000000);
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dm_unit.md
DM_UNIT -- requirements
Module: dm_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port Addr  input  32  byte address (ALU result).
REQ-005 SHALL have port DataIn  input  32  store data (register busB); low bits used for sub-word stores.
REQ-006 SHALL have port MemWr  input  1  store enable.
REQ-007 SHALL have port MemRd  input  1  load enable.
REQ-008 SHALL have port MemSize  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SHALL have port MemSigned  input  1  load extension: 1 sign-extend, 0 zero-extend.
REQ-010 SHALL have port DataOut  output  32  load result (feeds write-back select).
REQ-011 SHALL have port AddrErr  output  1  combinational alignment/size error for current access.
REQ-012 SHALL have port ErrSticky  output  1  registered flag, set by any erroneous access.
REQ-013 SHALL have port StoreCnt  output  16  registered count of committed stores.

Function
REQ-014 SHALL index words by Addr[log2(DEPTH_WORDS)+1:2]; higher Addr bits ignored (address wraps modulo 4*DEPTH_WORDS bytes).
REQ-015 SHALL use little-endian lanes: byte lane n = bits [8n+7:8n], selected by Addr[1:0]; halfword lane by Addr[1].
REQ-016 SHALL assert AddrErr when (MemRd|MemWr) and: MemSize=01 with Addr[0]=1; MemSize=10 with Addr[1:0]!=00; or MemSize=11.
REQ-017 SHALL hold AddrErr at 0 when MemRd=0 and MemWr=0.
REQ-018 SHALL read combinationally (same cycle): DataOut = selected lane of current word contents, extended per MemSigned to 32 bits; word loads ignore MemSigned.
REQ-019 SHALL drive DataOut = 0 when MemRd=0, AddrErr=1, or rst=1.
REQ-020 SHALL commit a store at rising edge when MemWr=1, AddrErr=0, rst=0: byte writes DataIn[7:0] to addressed lane, halfword writes DataIn[15:0] to addressed halfword, word writes DataIn; unaddressed lanes unchanged.
REQ-021 SHALL suppress the store entirely (no lane modified) when AddrErr=1.
REQ-022 SHALL, with MemRd=1 and MemWr=1 to same word, present pre-store contents on DataOut in that cycle; new contents visible from next cycle.
REQ-023 SHALL set ErrSticky at rising edge when AddrErr=1; remains 1 until rst.
REQ-024 SHALL increment StoreCnt by 1 per committed store; wraps 0xFFFF -> 0x0000; unchanged on suppressed stores.

Reset
REQ-025 SHALL, at rising edge with rst=1, clear all memory words to 0, ErrSticky to 0, StoreCnt to 0; rst has priority over a simultaneous store.
REQ-026 SHALL report DataOut=0, AddrErr unaffected-combinational, ErrSticky=0, StoreCnt=0 in cycle after reset.
REQ-027 SHALL, on rst asserted mid-sequence, discard the in-flight store of that cycle; next access sees zeroed memory.

Verification
REQ-028 SHALL cover: word store 0x12345678 to Addr 0x10, then word load Addr 0x10 -> DataOut=0x12345678, StoreCnt=1.
REQ-029 SHALL cover: byte store 0xAB to Addr 0x11 over word 0x12345678, load byte signed Addr 0x11 -> 0xFFFFFFAB, unsigned -> 0x000000AB, word load -> 0x1234AB78.
REQ-030 SHALL cover: halfword store to Addr 0x13 -> AddrErr=1, memory unchanged, ErrSticky=1 next cycle, StoreCnt unchanged.
REQ-031 SHALL cover: wrap-around, store word 0xCAFEF00D to Addr 4*DEPTH_WORDS+0x20, load Addr 0x20 -> 0xCAFEF00D.
REQ-032 SHALL cover: MemRd=MemWr=1 same word, old 0x1, new 0x2 -> DataOut=0x1 that cycle, 0x2 next cycle.
REQ-033 SHALL cover: rst with simultaneous store 0xFFFFFFFF to Addr 0x0 -> load Addr 0x0 after reset = 0, StoreCnt=0, ErrSticky=0.
